// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode, load-use stall FSM, branch redirect and the
// ID->EX->MEM->WB control pipeline for a 5-stage core.

`ifndef PIPE_CONTROL_DEFS
`define PIPE_CONTROL_DEFS
`define ALU_ADD          4'd0
`define ALU_SUB          4'd1
`define ALU_AND          4'd2
`define ALU_OR           4'd3
`define ALU_SLT          4'd4
`define ALU_SLL          4'd5
`define ALU_SRL          4'd6
`define ALU_SRA          4'd7
`define ALU_A_SEL_REG    1'b0
`define ALU_A_SEL_SHAMT  1'b1
`define ALU_B_SEL_REG    1'b0
`define ALU_B_SEL_IMM    1'b1
`define RD_DATA_SEL_ALU  1'b0
`define RD_DATA_SEL_MEM  1'b1
`endif

module pipe_control #(
    parameter int LOAD_STALL = 1,
    parameter int ENABLE_BNE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_id_valid,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    input  logic       i_equal,
    output logic       o_stall,
    output logic       o_flush,
    output logic       o_jump,
    output logic [3:0] o_ex_alu_op,
    output logic       o_ex_alu_a_sel,
    output logic       o_ex_alu_b_sel,
    output logic       o_mem_en,
    output logic       o_wb_rd_en,
    output logic [4:0] o_wb_rd_addr,
    output logic       o_wb_rd_data_sel,
    output logic       o_illegal
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;
    // The hazard cycle itself is the first stall cycle; the STALL state
    // covers the remaining LOAD_STALL-1 cycles.
    localparam logic [1:0] STALL_EXTRA = 2'(LOAD_STALL - 1);

    logic [0:0] r_state;
    logic [1:0] r_cnt;

    logic       w_legal, w_taken, w_reads_rs, w_reads_rt, w_is_load, w_wr, w_mem_en;
    logic [3:0] w_alu_op;
    logic       w_a_sel, w_b_sel, w_dsel;
    logic [4:0] w_dst;
    logic       w_hazard, w_bubble, w_dst_nz;

    // EX / MEM / WB control registers
    logic [3:0] r_ex_alu_op;
    logic       r_ex_a_sel, r_ex_b_sel, r_ex_mem_en, r_ex_wr, r_ex_dsel, r_ex_load;
    logic [4:0] r_ex_dst;
    logic       r_mem_mem_en, r_mem_wr, r_mem_dsel;
    logic [4:0] r_mem_dst;
    logic       r_wb_wr, r_wb_dsel;
    logic [4:0] r_wb_dst;
    logic       r_illegal;

    // Decode the ID instruction into EX-stage controls and hazard info
    always_comb begin
        w_legal    = 1'b0;
        w_taken    = 1'b0;
        w_reads_rs = 1'b0;
        w_reads_rt = 1'b0;
        w_is_load  = 1'b0;
        w_wr       = 1'b0;
        w_mem_en   = 1'b0;
        w_alu_op   = `ALU_SLL;
        w_a_sel    = `ALU_A_SEL_REG;
        w_b_sel    = `ALU_B_SEL_REG;
        w_dsel     = `RD_DATA_SEL_ALU;
        w_dst      = i_rd;
        case (i_opcode)
            6'h00: begin
                w_legal    = 1'b1;
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
                w_wr       = 1'b1;
                case (i_funct)
                    6'h20: w_alu_op = `ALU_ADD;
                    6'h22: w_alu_op = `ALU_SUB;
                    6'h24: w_alu_op = `ALU_AND;
                    6'h25: w_alu_op = `ALU_OR;
                    6'h2A: w_alu_op = `ALU_SLT;
                    6'h00: begin w_alu_op = `ALU_SLL; w_a_sel = `ALU_A_SEL_SHAMT; end
                    6'h02: begin w_alu_op = `ALU_SRL; w_a_sel = `ALU_A_SEL_SHAMT; end
                    6'h03: begin w_alu_op = `ALU_SRA; w_a_sel = `ALU_A_SEL_SHAMT; end
                    default: begin w_legal = 1'b0; w_wr = 1'b0; end
                endcase
            end
            6'h08: begin  // ADDI
                w_legal = 1'b1; w_reads_rs = 1'b1; w_wr = 1'b1; w_dst = i_rt;
                w_alu_op = `ALU_ADD; w_b_sel = `ALU_B_SEL_IMM;
            end
            6'h23: begin  // LW
                w_legal = 1'b1; w_reads_rs = 1'b1; w_wr = 1'b1; w_dst = i_rt;
                w_is_load = 1'b1; w_dsel = `RD_DATA_SEL_MEM;
                w_alu_op = `ALU_ADD; w_b_sel = `ALU_B_SEL_IMM;
            end
            6'h2B: begin  // SW
                w_legal = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_mem_en = 1'b1;
                w_alu_op = `ALU_ADD; w_b_sel = `ALU_B_SEL_IMM;
            end
            6'h04: begin  // BEQ
                w_legal = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_taken = i_equal;
            end
            6'h05: begin  // BNE
                if (ENABLE_BNE != 0) begin
                    w_legal = 1'b1; w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_taken = ~i_equal;
                end
            end
            6'h02: begin  // J
                w_legal = 1'b1; w_taken = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection, stall / redirect outputs
    assign w_dst_nz = (w_dst != 5'd0);
    assign w_hazard = (r_state == S_RUN) & i_id_valid & w_legal & r_ex_load &
                      ((w_reads_rs & (i_rs == r_ex_dst)) | (w_reads_rt & (i_rt == r_ex_dst)));
    assign o_stall  = w_hazard | (r_state == S_STALL);
    assign o_jump   = i_id_valid & w_legal & w_taken & ~o_stall;
    assign o_flush  = o_jump;
    // Branches carry no write/store controls, so they become bubbles naturally.
    assign w_bubble = ~i_id_valid | ~w_legal | o_stall;

    // Stall FSM: r_cnt holds the STALL-state cycles still to run
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                S_RUN: if (w_hazard && STALL_EXTRA != 2'd0) begin
                    r_state <= S_STALL;
                    r_cnt   <= STALL_EXTRA;
                end
                default: if (r_cnt <= 2'd1) begin
                    r_state <= S_RUN;
                    r_cnt   <= 2'd0;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            endcase
        end
    end

    // Advance control through EX, MEM and WB; bubbles enter EX on stall/invalid
    always_ff @(posedge i_clk) begin
        if (i_rst || w_bubble) begin
            r_ex_alu_op <= `ALU_SLL;
            r_ex_a_sel  <= `ALU_A_SEL_REG;
            r_ex_b_sel  <= `ALU_B_SEL_REG;
            r_ex_mem_en <= 1'b0;
            r_ex_wr     <= 1'b0;
            r_ex_dsel   <= `RD_DATA_SEL_ALU;
            r_ex_load   <= 1'b0;
            r_ex_dst    <= 5'd0;
        end else begin
            r_ex_alu_op <= w_alu_op;
            r_ex_a_sel  <= w_a_sel;
            r_ex_b_sel  <= w_b_sel;
            r_ex_mem_en <= w_mem_en;
            r_ex_wr     <= w_wr & w_dst_nz;
            r_ex_dsel   <= w_dsel;
            r_ex_load   <= w_is_load & w_dst_nz;
            r_ex_dst    <= w_dst;
        end
        if (i_rst) begin
            r_mem_mem_en <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_dsel   <= `RD_DATA_SEL_ALU;
            r_mem_dst    <= 5'd0;
            r_wb_wr      <= 1'b0;
            r_wb_dsel    <= `RD_DATA_SEL_ALU;
            r_wb_dst     <= 5'd0;
        end else begin
            r_mem_mem_en <= r_ex_mem_en;
            r_mem_wr     <= r_ex_wr;
            r_mem_dsel   <= r_ex_dsel;
            r_mem_dst    <= r_ex_dst;
            r_wb_wr      <= r_mem_wr;
            r_wb_dsel    <= r_mem_dsel;
            r_wb_dst     <= r_mem_dst;
        end
    end

    // One-cycle illegal-instruction pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) r_illegal <= 1'b0;
        else       r_illegal <= i_id_valid & ~w_legal;
    end

    assign o_ex_alu_op      = r_ex_alu_op;
    assign o_ex_alu_a_sel   = r_ex_a_sel;
    assign o_ex_alu_b_sel   = r_ex_b_sel;
    assign o_mem_en         = r_mem_mem_en;
    assign o_wb_rd_en       = r_wb_wr;
    assign o_wb_rd_addr     = r_wb_dst;
    assign o_wb_rd_data_sel = r_wb_dsel;
    assign o_illegal        = r_illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: three instances (LOAD_STALL 1/2/3, BNE off on the
// third) share stimulus and are checked against a per-instance stage model.
module tb_pipe_control;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_SLT = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7;
    localparam int LS  [3] = '{1, 2, 3};
    localparam int BNE [3] = '{1, 1, 0};

    typedef struct packed {
        logic [3:0] alu;
        logic       asel, bsel, mem_en, wr, dsel, ld;
        logic [4:0] dst;
    } stage_t;

    typedef struct packed {
        logic   legal, br, taken, rrs, rrt;
        stage_t s;
    } dec_t;

    logic clk = 1'b0;
    logic rst, valid, eq;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;

    logic       stall_v [3], flush_v [3], jump_v [3], asel_v [3], bsel_v [3];
    logic       mem_v [3], wben_v [3], wbsel_v [3], ill_v [3];
    logic [3:0] alu_v [3];
    logic [4:0] wbaddr_v [3];

    int n_chk = 0, n_err = 0;

    stage_t m_ex [3], m_mem [3], m_wb [3];
    int     m_left [3];
    logic   m_ill [3];
    logic   m_stalled [3];
    int     obs_cnt [3];

    always #5 clk = ~clk;

    pipe_control #(.LOAD_STALL(1), .ENABLE_BNE(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(valid), .i_opcode(op), .i_funct(fn),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_equal(eq),
        .o_stall(stall_v[0]), .o_flush(flush_v[0]), .o_jump(jump_v[0]),
        .o_ex_alu_op(alu_v[0]), .o_ex_alu_a_sel(asel_v[0]), .o_ex_alu_b_sel(bsel_v[0]),
        .o_mem_en(mem_v[0]), .o_wb_rd_en(wben_v[0]), .o_wb_rd_addr(wbaddr_v[0]),
        .o_wb_rd_data_sel(wbsel_v[0]), .o_illegal(ill_v[0]));

    pipe_control #(.LOAD_STALL(2), .ENABLE_BNE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(valid), .i_opcode(op), .i_funct(fn),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_equal(eq),
        .o_stall(stall_v[1]), .o_flush(flush_v[1]), .o_jump(jump_v[1]),
        .o_ex_alu_op(alu_v[1]), .o_ex_alu_a_sel(asel_v[1]), .o_ex_alu_b_sel(bsel_v[1]),
        .o_mem_en(mem_v[1]), .o_wb_rd_en(wben_v[1]), .o_wb_rd_addr(wbaddr_v[1]),
        .o_wb_rd_data_sel(wbsel_v[1]), .o_illegal(ill_v[1]));

    pipe_control #(.LOAD_STALL(3), .ENABLE_BNE(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_id_valid(valid), .i_opcode(op), .i_funct(fn),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_equal(eq),
        .o_stall(stall_v[2]), .o_flush(flush_v[2]), .o_jump(jump_v[2]),
        .o_ex_alu_op(alu_v[2]), .o_ex_alu_a_sel(asel_v[2]), .o_ex_alu_b_sel(bsel_v[2]),
        .o_mem_en(mem_v[2]), .o_wb_rd_en(wben_v[2]), .o_wb_rd_addr(wbaddr_v[2]),
        .o_wb_rd_data_sel(wbsel_v[2]), .o_illegal(ill_v[2]));

    function automatic stage_t bubble();
        stage_t b;
        b = '0;
        b.alu = A_SLL;
        return b;
    endfunction

    // Instruction set as a lookup: what each instruction reads, writes and drives
    function automatic dec_t decode(input int k, input logic [5:0] o, input logic [5:0] f,
                                    input logic [4:0] s, input logic [4:0] t,
                                    input logic [4:0] d, input logic e);
        dec_t r;
        r = '0;
        r.s = bubble();
        case (o)
            6'h00: begin
                r.legal = 1'b1; r.rrs = 1'b1; r.rrt = 1'b1;
                r.s.dst = d; r.s.wr = (d != 5'd0);
                case (f)
                    6'h20: r.s.alu = A_ADD;
                    6'h22: r.s.alu = A_SUB;
                    6'h24: r.s.alu = A_AND;
                    6'h25: r.s.alu = A_OR;
                    6'h2A: r.s.alu = A_SLT;
                    6'h00: begin r.s.alu = A_SLL; r.s.asel = 1'b1; end
                    6'h02: begin r.s.alu = A_SRL; r.s.asel = 1'b1; end
                    6'h03: begin r.s.alu = A_SRA; r.s.asel = 1'b1; end
                    default: r.legal = 1'b0;
                endcase
            end
            6'h08: begin
                r.legal = 1'b1; r.rrs = 1'b1; r.s.alu = A_ADD; r.s.bsel = 1'b1;
                r.s.dst = t; r.s.wr = (t != 5'd0);
            end
            6'h23: begin
                r.legal = 1'b1; r.rrs = 1'b1; r.s.alu = A_ADD; r.s.bsel = 1'b1;
                r.s.dst = t; r.s.wr = (t != 5'd0); r.s.ld = (t != 5'd0); r.s.dsel = 1'b1;
            end
            6'h2B: begin
                r.legal = 1'b1; r.rrs = 1'b1; r.rrt = 1'b1;
                r.s.alu = A_ADD; r.s.bsel = 1'b1; r.s.mem_en = 1'b1;
            end
            6'h04: begin r.legal = 1'b1; r.br = 1'b1; r.rrs = 1'b1; r.rrt = 1'b1; r.taken = e; end
            6'h05: if (BNE[k] != 0) begin
                r.legal = 1'b1; r.br = 1'b1; r.rrs = 1'b1; r.rrt = 1'b1; r.taken = ~e;
            end
            6'h02: begin r.legal = 1'b1; r.br = 1'b1; r.taken = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = bubble(); m_mem[k] = bubble(); m_wb[k] = bubble();
            m_left[k] = 0; m_ill[k] = 1'b0; m_stalled[k] = 1'b0;
        end
    endtask

    // One clock: drive, compare at negedge, advance the model at posedge
    task automatic step(input logic r, input logic v, input logic [5:0] o, input logic [5:0] f,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic e);
        stage_t nxt [3];
        int     nleft [3];
        logic   nill [3];
        rst = r; valid = v; op = o; fn = f; rs = s; rt = t; rd = d; eq = e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            dec_t dc;
            logic haz, stl, jmp;
            dc  = decode(k, o, f, s, t, d, e);
            haz = (m_left[k] == 0) && v && dc.legal && m_ex[k].ld &&
                  ((dc.rrs && s == m_ex[k].dst) || (dc.rrt && t == m_ex[k].dst));
            stl = haz || (m_left[k] > 0);
            jmp = v && dc.legal && dc.taken && !stl;
            m_stalled[k] = stl;
            if (stall_v[k] === 1'b1) obs_cnt[k]++;
            if (!r) begin
                chk("stall", k, 8'(stall_v[k]), 8'(stl));
                chk("jump", k, 8'(jump_v[k]), 8'(jmp));
                chk("flush", k, 8'(flush_v[k]), 8'(jmp));
                chk("ex_alu_op", k, 8'(alu_v[k]), 8'(m_ex[k].alu));
                chk("ex_a_sel", k, 8'(asel_v[k]), 8'(m_ex[k].asel));
                chk("ex_b_sel", k, 8'(bsel_v[k]), 8'(m_ex[k].bsel));
                chk("mem_en", k, 8'(mem_v[k]), 8'(m_mem[k].mem_en));
                chk("wb_rd_en", k, 8'(wben_v[k]), 8'(m_wb[k].wr));
                if (m_wb[k].wr) begin
                    chk("wb_rd_addr", k, 8'(wbaddr_v[k]), 8'(m_wb[k].dst));
                    chk("wb_rd_data_sel", k, 8'(wbsel_v[k]), 8'(m_wb[k].dsel));
                end
                chk("illegal", k, 8'(ill_v[k]), 8'(m_ill[k]));
            end
            nxt[k]   = (!v || !dc.legal || stl || dc.br) ? bubble() : dc.s;
            nleft[k] = haz ? LS[k] - 1 : ((m_left[k] > 0) ? m_left[k] - 1 : 0);
            nill[k]  = v && !dc.legal;
        end
        @(posedge clk);
        if (r) model_reset();
        else begin
            for (int k = 0; k < 3; k++) begin
                m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = nxt[k];
                m_left[k] = nleft[k]; m_ill[k] = nill[k];
            end
        end
        #1;
    endtask

    // Present an instruction and hold it in ID while any instance stalls
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic e);
        int guard = 0;
        do begin
            step(1'b0, 1'b1, o, f, s, t, d, e);
            guard++;
        end while ((m_stalled[0] || m_stalled[1] || m_stalled[2]) && guard < 8);
        if (guard >= 8) chk("issue_timeout", 0, 8'(guard), 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset with a taken jump held on the inputs
        step(1'b1, 1'b1, 6'h02, 6'h3F, 5'd1, 5'd1, 5'd1, 1'b1);
        step(1'b1, 1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b1);
        idle(1);
        // ADD r3,r1,r2 ; ADDI r4,r3,5
        issue(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(6'h08, 6'h00, 5'd3, 5'd4, 5'd0, 1'b0);
        idle(3);
        // LW r5 ; ADD r6,r5,r1 -- stall length must equal LOAD_STALL
        issue(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) obs_cnt[k] = 0;
        issue(6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0);
        for (int k = 0; k < 3; k++) chk("stall_len", k, 8'(obs_cnt[k]), 8'(LS[k]));
        idle(3);
        // Branches
        issue(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        issue(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        issue(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        idle(2);
        // LW r7 ; BEQ r7,r0 taken -- held branch redirects only after the stall
        issue(6'h23, 6'h00, 5'd2, 5'd7, 5'd0, 1'b0);
        issue(6'h04, 6'h00, 5'd7, 5'd0, 5'd0, 1'b1);
        idle(3);
        // Reset during the first stall cycle, then a normal instruction
        issue(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        step(1'b1, 1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0);
        for (int k = 0; k < 3; k++) obs_cnt[k] = 0;
        issue(6'h08, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) chk("post_reset_stall", k, 8'(obs_cnt[k]), 8'd0);
        idle(3);
        // Destination r0 and an undefined funct
        issue(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(6'h00, 6'h3F, 5'd1, 5'd2, 5'd9, 1'b0);
        idle(4);
        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [5:0] o, f;
            logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h23};
            logic [5:0] fns [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};
            o = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            f = fns[$urandom_range(0, 8)];
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), o, f,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 Parameter LOAD_STALL, default 1, is the number of bubble cycles inserted on a load-use hazard; legal range 1..3.
REQ-002 Parameter ENABLE_BNE, default 1, enables BNE (opcode 0x05) decode when 1; BNE is an invalid opcode when 0.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port id_valid, input, 1, a valid instruction is present in ID this cycle.
REQ-006 Ports opcode / funct, input, 6 each, ID instruction fields.
REQ-007 Ports rs / rt / rd, input, 5 each, ID register fields.
REQ-008 Port equal, input, 1, ID-stage register compare result (rs == rt).
REQ-009 Port stall, output, 1, freezes the PC and the IF/ID register.
REQ-010 Port flush, output, 1, converts IF/ID contents into a bubble.
REQ-011 Port jump, output, 1, selects the branch/jump target for the PC.
REQ-012 Ports ex_alu_op (4), ex_alu_a_sel (1), ex_alu_b_sel (1), output, EX-stage ALU controls using the `ALU_*, `ALU_A_SEL_*, `ALU_B_SEL_* encodings.
REQ-013 Port mem_en, output, 1, MEM-stage store enable.
REQ-014 Ports wb_rd_en (1), wb_rd_addr (5), wb_rd_data_sel (1), output, WB-stage register write controls using `RD_DATA_SEL_*.
REQ-015 Port illegal, output, 1, registered one-cycle pulse when a valid ID instruction has an undefined opcode or funct.

Function
REQ-016 Decode SHALL be ADD/SUB/AND/OR/SLT/SLL/SRA/SRL (R-type), ADDI, LW, SW, BEQ, BNE, J (0x02); field values and control meanings match the single-cycle decoder.
REQ-017 Decoded controls SHALL flow ID->EX->MEM->WB through internal registers: ALU controls visible one cycle after ID, mem_en two cycles after, wb_* three cycles after.
REQ-018 Destination register SHALL be rd for R-type and rt for ADDI/LW; a destination of 0 SHALL force wb_rd_en = 0.
REQ-019 Invalid or non-valid ID instructions SHALL enter EX as a bubble: wb_rd_en = 0, mem_en = 0, ex_alu_op = `ALU_SLL, selects = REG.
REQ-020 Load-use hazard: EX holds a valid LW with destination D != 0 and the ID instruction reads rs == D, or reads rt == D (R-type, SW, BEQ, BNE).
REQ-021 FSM states RUN and STALL; RUN->STALL on hazard with counter loaded to LOAD_STALL-1 and stall = 1; STALL decrements, stall = 1 while in STALL, returns to RUN when counter is 0 at that edge.
REQ-022 During every stall cycle a bubble SHALL be injected into EX while MEM/WB continue to advance; ID decode SHALL be held, not re-latched.
REQ-023 LOAD_STALL = 1 SHALL give exactly one stall cycle; LOAD_STALL = N SHALL give exactly N consecutive stall cycles.
REQ-024 BEQ with equal = 1, BNE with equal = 0, or J, valid in ID and not stalled, SHALL assert jump = 1 and flush = 1 combinationally in that cycle.
REQ-025 A branch stalled by a load-use hazard SHALL NOT assert jump or flush until its final unstalled ID cycle.
REQ-026 Branches and J SHALL enter EX as bubbles (no register write, no store).
REQ-027 Hazard and branch in the same cycle: the hazard wins; stall = 1, jump = 0, flush = 0.

Reset
REQ-028 While rst = 1 at a clock edge, all pipeline control registers SHALL clear to bubble values, the FSM SHALL enter RUN with counter 0, and illegal SHALL clear.
REQ-029 The cycle after reset, stall, flush, jump, mem_en, wb_rd_en and illegal SHALL read 0 regardless of inputs held during reset.
REQ-030 Reset asserted mid-stall SHALL abort the stall; the stall count does not resume.

Verification
REQ-031 ADD r3,r1,r2 then ADDI r4,r3,5: ex_alu_op = `ALU_ADD at cycle 1, wb_rd_en = 1 with wb_rd_addr = 3 at cycle 3; no stall.
REQ-032 LW r5 then ADD r6,r5,r1 with LOAD_STALL = 2: stall high for exactly 2 cycles, EX shows 2 bubbles, ADD reaches EX on the third cycle.
REQ-033 BEQ with equal = 1: jump = flush = 1 for one cycle; BNE with equal = 1: jump = 0; with ENABLE_BNE = 0, BNE gives illegal = 1 next cycle.
REQ-034 LW r7 followed by BEQ r7,r0 with equal = 1: stall 1 cycle with jump = 0, then jump = 1 in the next cycle.
REQ-035 Assert rst during the first of 3 stall cycles: the next cycle shows stall = 0 and wb_rd_en = 0; the following instruction decodes normally.
REQ-036 ADDI r0,r1,1, and R-type funct 0x3F: wb_rd_en stays 0 for both; illegal pulses for the funct 0x3F case only.
